// File: rtl/dense_mac_seq_if.sv
// Handshake and memory-read bus between dense_mac_seq and its weight/pixel banks.
// master = memory/controller side, slave = the sequencer itself.
interface dense_mac_seq_if #(
    parameter int NC    = 9,
    parameter int ACC_W = 26
);
    logic                      start;
    logic [16*(NC+1)-1:0]      weights_in;
    logic [7:0]                pix1;
    logic [7:0]                pix2;
    logic [9:0]                addr1;
    logic [9:0]                addr2;
    logic                      busy;
    logic                      done;
    logic                      scores_valid;
    logic [(NC+1)*ACC_W-1:0]   scores;
    logic [3:0]                class_idx;

    modport master (
        output start, weights_in, pix1, pix2,
        input  addr1, addr2, busy, done, scores_valid, scores, class_idx
    );

    modport slave (
        input  start, weights_in, pix1, pix2,
        output addr1, addr2, busy, done, scores_valid, scores, class_idx
    );
endinterface

// File: rtl/dense_mac_seq.sv
// Dual-read address sequencer and per-class signed MAC for the dense output layer.
// Define DENSE_MAC_ARGMAX_EN to build the sequential argmax (ARG state) driving class_idx.
module dense_mac_seq #(
    parameter int NC    = 9,
    parameter int DEPTH = 784,
    parameter int ACC_W = 26
) (
    input  logic            clk,
    input  logic            rst,
    dense_mac_seq_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, ARG, DONE} state_t;

    localparam logic [9:0] LAST_ADDR = 10'(DEPTH - 2);

    state_t state, state_nxt;
    logic   start_acc;
    logic   finish;
    logic   vld_p0;
    logic   vld_p1;

    logic signed [ACC_W-1:0] acc      [NC+1];
    logic signed [17:0]      lane_sum [NC+1];

`ifdef DENSE_MAC_ARGMAX_EN
    logic [3:0]              arg_cnt;
    logic signed [ACC_W-1:0] best;
`endif

    // Two 8s x 9s lane products summed to 18 bits; pixels are zero-extended.
    function automatic logic signed [17:0] pair_sum(
        input logic signed [7:0] w0,
        input logic signed [7:0] w1,
        input logic [7:0]        p0,
        input logic [7:0]        p1
    );
        logic signed [16:0] m0;
        logic signed [16:0] m1;
        m0 = $signed({{9{w0[7]}}, w0}) * $signed({9'd0, p0});
        m1 = $signed({{9{w1[7]}}, w1}) * $signed({9'd0, p1});
        return {m0[16], m0} + {m1[16], m1};
    endfunction

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [17:0] v);
        return {{(ACC_W-18){v[17]}}, v};
    endfunction

    always_comb begin
        for (int c = 0; c <= NC; c++) begin
            lane_sum[c] = pair_sum(bus.weights_in[(2*c)*8 +: 8],
                                   bus.weights_in[(2*c+1)*8 +: 8],
                                   bus.pix1, bus.pix2);
        end
    end

    for (genvar g = 0; g <= NC; g++) begin : g_scores
        assign bus.scores[g*ACC_W +: ACC_W] = acc[g];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    start_acc = 1'b1;
                end
            end
            RUN:   if (bus.addr1 == LAST_ADDR) state_nxt = DRAIN;
`ifdef DENSE_MAC_ARGMAX_EN
            DRAIN: state_nxt = ARG;
            ARG:   if (arg_cnt == 4'(NC)) state_nxt = DONE;
`else
            DRAIN: state_nxt = DONE;
`endif
            DONE: begin
                state_nxt = IDLE;
                finish    = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // p0: address pair on the bus; p1: matching read data on weights_in/pix*.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.addr1        <= '0;
            bus.addr2        <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.scores_valid <= 1'b0;
            vld_p0           <= 1'b0;
            vld_p1           <= 1'b0;
            for (int c = 0; c <= NC; c++) acc[c] <= '0;
`ifdef DENSE_MAC_ARGMAX_EN
            bus.class_idx    <= '0;
            arg_cnt          <= '0;
            best             <= '0;
`endif
        end else begin
            bus.done <= 1'b0;
            vld_p1   <= vld_p0;
            if (start_acc) begin
                bus.addr1        <= 10'd0;
                bus.addr2        <= 10'd1;
                bus.busy         <= 1'b1;
                bus.scores_valid <= 1'b0;
                vld_p0           <= 1'b1;
                for (int c = 0; c <= NC; c++) acc[c] <= '0;
`ifdef DENSE_MAC_ARGMAX_EN
                bus.class_idx    <= '0;
`endif
            end else begin
                if (state == RUN) begin
                    if (bus.addr1 == LAST_ADDR) begin
                        bus.addr1 <= '0;
                        bus.addr2 <= '0;
                        vld_p0    <= 1'b0;
                    end else begin
                        bus.addr1 <= bus.addr1 + 10'd2;
                        bus.addr2 <= bus.addr2 + 10'd2;
                    end
                end
                if (vld_p1) begin
                    for (int c = 0; c <= NC; c++) acc[c] <= acc[c] + sext(lane_sum[c]);
                end
`ifdef DENSE_MAC_ARGMAX_EN
                if (state == DRAIN) arg_cnt <= '0;
                // Strictly-greater replace keeps the lowest index on ties.
                if (state == ARG) begin
                    if (arg_cnt == 4'd0 || acc[arg_cnt] > best) begin
                        best          <= acc[arg_cnt];
                        bus.class_idx <= arg_cnt;
                    end
                    arg_cnt <= arg_cnt + 4'd1;
                end
`endif
                if (finish) begin
                    bus.done         <= 1'b1;
                    bus.scores_valid <= 1'b1;
                    bus.busy         <= 1'b0;
                end
            end
        end
    end

`ifndef DENSE_MAC_ARGMAX_EN
    assign bus.class_idx = '0;
`endif
endmodule

// File: tb/tb_dense_mac_seq.sv
// Testbench for dense_mac_seq: 1-cycle-latency memory model, table vectors,
// random runs against a dot-product reference, and multi-cycle corner sequences.
module tb_dense_mac_seq;
    localparam int NC    = 9;
    localparam int DEPTH = 784;
    localparam int ACC_W = 26;
`ifdef DENSE_MAC_ARGMAX_EN
    localparam int LAT = DEPTH/2 + 2 + NC + 1;
`else
    localparam int LAT = DEPTH/2 + 2;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dense_mac_seq_if #(.NC(NC), .ACC_W(ACC_W)) bus();
    dense_mac_seq #(.NC(NC), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic signed [7:0] wmem [0:NC][0:1023];
    logic [7:0]        pmem [0:1023];

    // Synchronous read memories: data for addresses of cycle k appears in cycle k+1.
    always @(posedge clk) begin
        for (int c = 0; c <= NC; c++) begin
            bus.weights_in[16*c +: 8]     <= wmem[c][bus.addr1];
            bus.weights_in[16*c + 8 +: 8] <= wmem[c][bus.addr2];
        end
        bus.pix1 <= pmem[bus.addr1];
        bus.pix2 <= pmem[bus.addr2];
    end

    int     checks = 0;
    int     failures = 0;
    longint exp_sc [0:NC];
    int     exp_idx;
    int     r_lat, r_npairs, r_valid0;
    bit     r_order_ok, r_busy_ok;
    longint r_sc0;

    typedef struct {
        int     w;
        int     p;
        longint sc;
    } vec_t;
    vec_t vt [5];

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint score(input int c);
        logic signed [ACC_W-1:0] v;
        v = bus.scores[c*ACC_W +: ACC_W];
        return longint'(v);
    endfunction

    function automatic int idx_expect();
`ifdef DENSE_MAC_ARGMAX_EN
        return exp_idx;
`else
        return 0;
`endif
    endfunction

    task automatic fill_const(input int w, input int p);
        for (int a = 0; a < 1024; a++) begin
            for (int c = 0; c <= NC; c++) wmem[c][a] = (a < DEPTH) ? 8'(w) : 8'd0;
            pmem[a] = (a < DEPTH) ? 8'(p) : 8'd0;
        end
    endtask

    task automatic fill_rand();
        for (int a = 0; a < 1024; a++) begin
            for (int c = 0; c <= NC; c++) wmem[c][a] = 8'($urandom);
            pmem[a] = 8'($urandom);
        end
    endtask

    // Reference: plain dot products over the stored memories, then first maximum.
    function automatic void model();
        for (int c = 0; c <= NC; c++) begin
            longint s = 0;
            for (int a = 0; a < DEPTH; a++) s += longint'(wmem[c][a]) * longint'(pmem[a]);
            exp_sc[c] = s;
        end
        exp_idx = 0;
        for (int c = 1; c <= NC; c++) if (exp_sc[c] > exp_sc[exp_idx]) exp_idx = c;
    endfunction

    task automatic check_scores(input string tag);
        for (int c = 0; c <= NC; c++) check($sformatf("%s score%0d", tag, c), score(c), exp_sc[c]);
    endtask

    // One inference; extra_at > 0 re-pulses start so that it is sampled at edge E(extra_at).
    task automatic do_run(input int extra_at);
        int k;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        r_valid0   = int'(bus.scores_valid);
        r_sc0      = score(0);
        k          = 0;
        r_lat      = -1;
        r_npairs   = 0;
        r_order_ok = 1'b1;
        r_busy_ok  = 1'b1;
        while (k < 2000) begin
            if (bus.busy && (int'(bus.addr2) == int'(bus.addr1) + 1)) begin
                if (int'(bus.addr1) != 2*r_npairs) r_order_ok = 1'b0;
                r_npairs++;
            end
            if (bus.done) begin
                r_lat = k;
                if (bus.busy) r_busy_ok = 1'b0;
                break;
            end
            if (!bus.busy) r_busy_ok = 1'b0;
            bus.start = (k == extra_at - 1);
            @(posedge clk);
            #1;
            k++;
        end
        bus.start = 1'b0;
    endtask

    initial begin
        int nd;
        vt[0] = '{1, 1, 64'sd784};
        vt[1] = '{-128, 255, -64'sd25589760};
        vt[2] = '{127, 255, 64'sd25389840};
        vt[3] = '{-1, 1, -64'sd784};
        vt[4] = '{3, 0, 64'sd0};

        rst       = 1'b0;
        bus.start = 1'b0;
        fill_const(0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset valid", bus.scores_valid, 0);
        check("reset addr1", bus.addr1, 0);
        check("reset addr2", bus.addr2, 0);
        check("reset class_idx", bus.class_idx, 0);
        check("reset score0", score(0), 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            fill_const(vt[i].w, vt[i].p);
            do_run(0);
            check($sformatf("vec%0d latency", i), r_lat, LAT);
            check($sformatf("vec%0d valid at done", i), bus.scores_valid, 1);
            check($sformatf("vec%0d valid cleared at start", i), r_valid0, 0);
            check($sformatf("vec%0d pair count", i), r_npairs, DEPTH/2);
            check($sformatf("vec%0d pair order", i), r_order_ok, 1);
            check($sformatf("vec%0d busy span", i), r_busy_ok, 1);
            check($sformatf("vec%0d class_idx", i), bus.class_idx, 0);
            for (int c = 0; c <= NC; c++)
                check($sformatf("vec%0d score%0d", i, c), score(c), vt[i].sc);
        end
        check("score cleared at start", r_sc0, 0);

        for (int r = 0; r < 3; r++) begin
            fill_rand();
            model();
            do_run(0);
            check($sformatf("rand%0d latency", r), r_lat, LAT);
            check_scores($sformatf("rand%0d", r));
            check($sformatf("rand%0d class_idx", r), bus.class_idx, idx_expect());
        end

        // Start pulse mid-run must not disturb the run or add a done.
        fill_const(1, 1);
        do_run(50);
        check("busy-start latency", r_lat, LAT);
        for (int c = 0; c <= NC; c++) check($sformatf("busy-start score%0d", c), score(c), 784);
        nd = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.done) nd++;
        end
        check("busy-start extra done", nd, 0);
        check("busy-start idle", bus.busy, 0);

        // Asynchronous reset in the middle of RUN.
        fill_const(1, 1);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        check("pre-reset busy", bus.busy, 1);
        rst = 1'b0;
        #1;
        check("mid-reset busy", bus.busy, 0);
        check("mid-reset addr1", bus.addr1, 0);
        check("mid-reset addr2", bus.addr2, 0);
        check("mid-reset valid", bus.scores_valid, 0);
        for (int c = 0; c <= NC; c++) check($sformatf("mid-reset score%0d", c), score(c), 0);
        @(negedge clk);
        rst = 1'b1;
        do_run(0);
        check("post-reset latency", r_lat, LAT);
        for (int c = 0; c <= NC; c++) check($sformatf("post-reset score%0d", c), score(c), 784);

`ifdef DENSE_MAC_ARGMAX_EN
        fill_const(1, 1);
        for (int a = 0; a < DEPTH; a++) wmem[7][a] = 8'sd2;
        do_run(0);
        check("argmax class7", bus.class_idx, 7);
        fill_const(1, 1);
        for (int a = 0; a < DEPTH; a++) begin
            wmem[3][a] = 8'sd2;
            wmem[5][a] = 8'sd2;
        end
        do_run(0);
        check("argmax tie 3/5", bus.class_idx, 3);
        check("argmax tie score3", score(3), 1568);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
